gpr_file_sized: RTL and testbench

//  Parametrised x86 general-purpose register file for the AGEX datapath; replaces the fixed 4x regfile8x8$ slice.

---
 rtl/gpr_pkg.sv | 30 +++
 rtl/gpr_lane_map.sv | 25 ++
 rtl/gpr_file_sized.sv | 99 +++++++++
 tb/tb_gpr_file_sized.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared operand-size encodings and lane-mapping helpers for the sized GPR file.
package gpr_pkg;

   localparam logic [1:0] SZ_B   = 2'b00;
   localparam logic [1:0] SZ_W   = 2'b01;
   localparam logic [1:0] SZ_D   = 2'b10;
   localparam logic [1:0] SZ_ILL = 2'b11;

   // Widest register the mask helper can describe; callers truncate to their DATA_W.
   localparam int GPR_MAX_W = 128;

   function automatic int gpr_phys(input int sel, input logic [1:0] size, input bit hi_alias);
      if (size == SZ_B && hi_alias && sel >= 4 && sel <= 7) return sel - 4;
      return sel;
   endfunction

   function automatic logic [GPR_MAX_W-1:0] gpr_lane_mask(input int sel, input logic [1:0] size,
                                                          input bit hi_alias, input int data_w);
      logic [GPR_MAX_W-1:0] m;
      m = '0;
      case (size)
         SZ_B: m[15:0] = (hi_alias && sel >= 4 && sel <= 7) ? 16'hFF00 : 16'h00FF;
         SZ_W: m[15:0] = 16'hFFFF;
         SZ_D: for (int i = 0; i < GPR_MAX_W; i++) m[i] = (i < data_w);
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/gpr_lane_map.sv
// Maps an architectural (sel, size) pair onto a physical register, a lane mask and a right-justify shift.
module gpr_lane_map
   import gpr_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int SEL_W    = 3,
   parameter int HI_ALIAS = 1
) (
   input  logic [SEL_W-1:0]  sel,
   input  logic [1:0]        size,
   output logic [SEL_W-1:0]  phys,
   output logic [DATA_W-1:0] mask,
   output logic [3:0]        shift,
   output logic              legal
);

   always_comb begin
      legal = (size != SZ_ILL);
      phys  = SEL_W'(gpr_phys(int'(sel), size, HI_ALIAS != 0));
      mask  = DATA_W'(gpr_lane_mask(int'(sel), size, HI_ALIAS != 0, DATA_W));
      // A legal lane with an empty low byte can only be the high-byte alias.
      shift = (legal && mask[7:0] == 8'h00) ? 4'd8 : 4'd0;
   end

endmodule

// File: rtl/gpr_file_sized.sv
// Sized x86 GPR file: NRD combinational read ports, one merge-on-write port, and a busy scoreboard.
module gpr_file_sized
   import gpr_pkg::*;
#(
   parameter int  DATA_W   = 32,
   parameter int  NREGS    = 8,
   parameter int  NRD      = 2,
   parameter int  BYPASS   = 1,
   parameter int  HI_ALIAS = 1,
   localparam int SEL_W    = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*SEL_W-1:0]  rd_sel,
   input  logic [NRD*2-1:0]      rd_size,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  wr_en,
   input  logic [SEL_W-1:0]      wr_sel,
   input  logic [1:0]            wr_size,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  sb_set,
   input  logic [SEL_W-1:0]      sb_sel
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  busy;
   logic [NREGS-1:0]  busy_next;

   logic [SEL_W-1:0]  rp_phys  [NRD];
   logic [DATA_W-1:0] rp_mask  [NRD];
   logic [3:0]        rp_shift [NRD];
   logic              rp_legal [NRD];

   logic [SEL_W-1:0]  wr_phys;
   logic [DATA_W-1:0] wr_mask;
   logic [3:0]        wr_shift;
   logic              wr_legal;
   logic              wr_hit;
   logic [DATA_W-1:0] wr_merged;
   logic [DATA_W-1:0] rd_src;

   for (genvar g = 0; g < NRD; g++) begin : g_rd_map
      gpr_lane_map #(.DATA_W(DATA_W), .SEL_W(SEL_W), .HI_ALIAS(HI_ALIAS)) u_rd_map (
         .sel   (rd_sel[g*SEL_W +: SEL_W]),
         .size  (rd_size[g*2 +: 2]),
         .phys  (rp_phys[g]),
         .mask  (rp_mask[g]),
         .shift (rp_shift[g]),
         .legal (rp_legal[g])
      );
   end

   gpr_lane_map #(.DATA_W(DATA_W), .SEL_W(SEL_W), .HI_ALIAS(HI_ALIAS)) u_wr_map (
      .sel   (wr_sel),
      .size  (wr_size),
      .phys  (wr_phys),
      .mask  (wr_mask),
      .shift (wr_shift),
      .legal (wr_legal)
   );

   assign wr_hit    = wr_en & wr_legal;
   assign wr_merged = (regs[wr_phys] & ~wr_mask) | ((wr_data << wr_shift) & wr_mask);

   // Set is applied after clear so a newly issued writer wins over the retiring one.
   always_comb begin
      busy_next = busy;
      if (wr_hit) busy_next[wr_phys] = 1'b0;
      if (sb_set) busy_next[sb_sel]  = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
         busy <= '0;
      end else begin
         if (wr_hit) regs[wr_phys] <= wr_merged;
         busy <= busy_next;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      rd_src  = '0;
      for (int i = 0; i < NRD; i++) begin
         if ((BYPASS != 0) && wr_hit && wr_phys == rp_phys[i]) rd_src = wr_merged;
         else                                                   rd_src = regs[rp_phys[i]];
         if (!rst && rp_legal[i]) begin
            rd_data[i*DATA_W +: DATA_W] = (rd_src & rp_mask[i]) >> rp_shift[i];
            rd_busy[i] = busy[rp_phys[i]] &
                         ~((BYPASS != 0) && wr_hit && wr_phys == rp_phys[i] &&
                           !(sb_set && sb_sel == rp_phys[i]));
         end
      end
   end

endmodule

// File: tb/tb_gpr_file_sized.sv
// Directed bench driving a BYPASS=1 and a BYPASS=0 instance from the same stimulus.
module tb_gpr_file_sized;
   import gpr_pkg::*;

   logic        clk;
   logic        rst;
   logic [5:0]  rd_sel;
   logic [3:0]  rd_size;
   logic [63:0] rd_data_b, rd_data_n;
   logic [1:0]  rd_busy_b, rd_busy_n;
   logic        wr_en;
   logic [2:0]  wr_sel;
   logic [1:0]  wr_size;
   logic [31:0] wr_data;
   logic        sb_set;
   logic [2:0]  sb_sel;

   int n_vec = 0;
   int n_err = 0;

   gpr_file_sized #(.BYPASS(1)) u_dut_byp (
      .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_size(rd_size), .rd_data(rd_data_b),
      .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_sel(wr_sel), .wr_size(wr_size),
      .wr_data(wr_data), .sb_set(sb_set), .sb_sel(sb_sel)
   );

   gpr_file_sized #(.BYPASS(0)) u_dut_nob (
      .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_size(rd_size), .rd_data(rd_data_n),
      .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_size(wr_size),
      .wr_data(wr_data), .sb_set(sb_set), .sb_sel(sb_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input int p, input logic [31:0] exp_b, input logic [31:0] exp_n);
      chk({tag, " data/byp"}, rd_data_b[p*32 +: 32], exp_b);
      chk({tag, " data/nob"}, rd_data_n[p*32 +: 32], exp_n);
   endtask

   task automatic chk_bz(input string tag, input int p, input logic exp_b, input logic exp_n);
      chk({tag, " busy/byp"}, 32'(rd_busy_b[p]), 32'(exp_b));
      chk({tag, " busy/nob"}, 32'(rd_busy_n[p]), 32'(exp_n));
   endtask

   task automatic rd(input int p, input int sel, input logic [1:0] sz);
      rd_sel[p*3 +: 3]  = sel[2:0];
      rd_size[p*2 +: 2] = sz;
   endtask

   task automatic wr(input int sel, input logic [1:0] sz, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_sel  = sel[2:0];
      wr_size = sz;
      wr_data = d;
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      sb_set = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rd_sel = '0; rd_size = '0; wr_en = 1'b0; wr_sel = '0;
      wr_size = '0; wr_data = '0; sb_set = 1'b0; sb_sel = '0;
      #3;
      chk_rd("in_reset", 0, 32'h0, 32'h0);
      tick();
      tick();
      rst = 1'b0;

      // Reset state on every select and size.
      for (int s = 0; s < 8; s++) begin
         for (int z = 0; z < 4; z++) begin
            rd(0, s, z[1:0]);
            rd(1, 7 - s, z[1:0]);
            #1;
            chk_rd($sformatf("rst p0 s%0d z%0d", s, z), 0, 32'h0, 32'h0);
            chk_rd($sformatf("rst p1 s%0d z%0d", 7 - s, z), 1, 32'h0, 32'h0);
            chk_bz($sformatf("rst p0 s%0d z%0d", s, z), 0, 1'b0, 1'b0);
         end
      end

      // Partial merge.
      tick();
      wr(0, SZ_D, 32'h11223344); tick();
      wr(4, SZ_B, 32'h000000AA); tick();
      idle();
      rd(0, 0, SZ_D); rd(1, 0, SZ_B); #1;
      chk_rd("eax after ah", 0, 32'h1122AA44, 32'h1122AA44);
      chk_rd("al after ah",  1, 32'h00000044, 32'h00000044);
      rd(1, 4, SZ_B); #1;
      chk_rd("ah after ah",  1, 32'h000000AA, 32'h000000AA);
      tick();
      wr(0, SZ_W, 32'h0000BEEF); tick();
      idle();
      rd(0, 0, SZ_D); rd(1, 4, SZ_B); #1;
      chk_rd("eax after ax", 0, 32'h1122BEEF, 32'h1122BEEF);
      chk_rd("ah after ax",  1, 32'h000000BE, 32'h000000BE);
      rd(1, 0, SZ_D); #1;
      chk_rd("same reg p1", 1, 32'h1122BEEF, 32'h1122BEEF);

      // Bypass, then whole-register bypass of a high-byte write.
      tick();
      rd(0, 1, SZ_D); wr(1, SZ_D, 32'hDEADBEEF); #1;
      chk_rd("ecx bypass", 0, 32'hDEADBEEF, 32'h00000000);
      tick();
      idle(); #1;
      chk_rd("ecx next", 0, 32'hDEADBEEF, 32'hDEADBEEF);
      tick();
      rd(0, 0, SZ_D); wr(4, SZ_B, 32'h00000055); #1;
      chk_rd("eax during ah", 0, 32'h112255EF, 32'h1122BEEF);
      tick();
      idle(); #1;
      chk_rd("eax after ah2", 0, 32'h112255EF, 32'h112255EF);

      // Scoreboard: set EDX, clear via DH.
      tick();
      rd(0, 2, SZ_B); sb_set = 1'b1; sb_sel = 3'd2; #1;
      chk_bz("dl before set", 0, 1'b0, 1'b0);
      tick();
      sb_set = 1'b0; #1;
      chk_bz("dl after set", 0, 1'b1, 1'b1);
      wr(6, SZ_B, 32'h00000077); #1;
      chk_bz("dl during dh", 0, 1'b0, 1'b1);
      tick();
      idle(); #1;
      chk_bz("dl after dh", 0, 1'b0, 1'b0);
      chk_rd("dl value", 0, 32'h0, 32'h0);
      rd(0, 2, SZ_W); #1;
      chk_rd("dx value", 0, 32'h00007700, 32'h00007700);

      // Set and write on the same register in one cycle: set wins.
      tick();
      rd(1, 3, SZ_D); sb_set = 1'b1; sb_sel = 3'd3; wr(3, SZ_D, 32'h12345678); #1;
      chk_bz("ebx set+wr", 1, 1'b0, 1'b0);
      tick();
      idle(); #1;
      chk_bz("ebx after", 1, 1'b1, 1'b1);
      chk_rd("ebx data", 1, 32'h12345678, 32'h12345678);

      // Illegal size write is dropped entirely.
      tick();
      wr(6, SZ_D, 32'hCAFEF00D); tick();
      idle(); sb_set = 1'b1; sb_sel = 3'd6; tick();
      sb_set = 1'b0;
      rd(0, 6, SZ_D); wr(6, SZ_ILL, 32'hFFFFFFFF); #1;
      chk_bz("esi during ill", 0, 1'b1, 1'b1);
      chk_rd("esi during ill", 0, 32'hCAFEF00D, 32'hCAFEF00D);
      tick();
      idle(); #1;
      chk_bz("esi after ill", 0, 1'b1, 1'b1);
      chk_rd("esi after ill", 0, 32'hCAFEF00D, 32'hCAFEF00D);
      rd(1, 6, SZ_ILL); #1;
      chk_rd("size11 read", 1, 32'h0, 32'h0);
      chk_bz("size11 read", 1, 1'b0, 1'b0);

      // Asynchronous reset between edges with a write and a set in flight.
      tick();
      rd(0, 0, SZ_D); rd(1, 6, SZ_D); wr(1, SZ_D, 32'h00000099); sb_set = 1'b1; sb_sel = 3'd0; #1;
      chk_rd("pre rst eax", 0, 32'h112255EF, 32'h112255EF);
      chk_bz("pre rst esi", 1, 1'b1, 1'b1);
      rst = 1'b1; #1;
      chk_rd("mid rst p0", 0, 32'h0, 32'h0);
      chk_rd("mid rst p1", 1, 32'h0, 32'h0);
      chk_bz("mid rst p0", 0, 1'b0, 1'b0);
      chk_bz("mid rst p1", 1, 1'b0, 1'b0);
      idle(); #1;
      rst = 1'b0; #1;
      chk_rd("post rst eax", 0, 32'h0, 32'h0);
      chk_bz("post rst esi", 1, 1'b0, 1'b0);
      tick();
      rd(0, 1, SZ_D); rd(1, 0, SZ_D); #1;
      chk_rd("lost ecx wr", 0, 32'h0, 32'h0);
      chk_bz("lost eax set", 1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
